// File: rtl/apb_timer_regs_mc.sv
// APB3 register bank for an NCH-channel timer: phase tracking, programmable
// wait states, W1C status with hardware set, masked and registered interrupt.

module apb_timer_regs_ch #(
  parameter int DW = 8
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          wr_tcr,
  input  logic          wr_tdr,
  input  logic          wr_tsr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] tsr_set,
  output logic [DW-1:0] tcr,
  output logic [DW-1:0] tdr,
  output logic [DW-1:0] tsr,
  output logic          tdr_wr
);
  logic [DW-1:0] clr;
  assign clr = wr_tsr ? wdata : '0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tcr    <= '0;
      tdr    <= '0;
      tsr    <= '0;
      tdr_wr <= 1'b0;
    end else begin
      if (wr_tcr) tcr <= wdata;
      if (wr_tdr) tdr <= wdata;
      tdr_wr <= wr_tdr;
      // hardware set beats a same-cycle W1C
      tsr <= (tsr & ~clr) | tsr_set;
    end
  end
endmodule

module apb_timer_regs_mc #(
  parameter int NCH         = 4,
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [AW-1:0]     PADDR,
  input  logic [DW-1:0]     PWDATA,
  output logic [DW-1:0]     PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NCH*DW-1:0] tcr_o,
  output logic [NCH*DW-1:0] tdr_o,
  output logic [NCH-1:0]    tdr_wr_o,
  input  logic [NCH*DW-1:0] tcnt_i,
  input  logic [NCH*DW-1:0] tsr_set_i,
  output logic              irq_o
);
  localparam int            CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW-1:0] CH_END = AW'(4 * NCH);
  localparam logic [AW-1:0] A_IER  = AW'(8'h80);
  localparam logic [AW-1:0] A_IPR  = AW'(8'h81);
  localparam logic [1:0]    WS     = 2'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic          ch_hit;
    logic [CW-1:0] ch;
    logic [1:0]    off;
    logic          ier;
    logic          ipr;
    logic          err;
  } dec_t;

  state_t                   state;
  logic [1:0]               wcnt, wcnt_eff;
  logic                     acc_first, in_acc, wr_commit;
  dec_t                     dec;
  logic [NCH-1:0]           ier, ipr;
  logic [NCH-1:0][DW-1:0]   tcr, tdr, tsr, tcnt, tset;
  logic [DW-1:0]            rdata;

  assign tcnt  = tcnt_i;
  assign tset  = tsr_set_i;
  assign tcr_o = tcr;
  assign tdr_o = tdr;

  always_comb begin
    dec        = '0;
    dec.ch_hit = PADDR < CH_END;
    dec.ch     = PADDR[CW+1:2];
    dec.off    = PADDR[1:0];
    dec.ier    = PADDR == A_IER;
    dec.ipr    = PADDR == A_IPR;
    dec.err    = PWRITE ? ~((dec.ch_hit & (dec.off != 2'd3)) | dec.ier)
                        : ~(dec.ch_hit | dec.ier | dec.ipr);
  end

  // The first ACCESS cycle is seen while the tracker still holds SETUP,
  // so its wait count is taken as zero.
  assign acc_first = (state == SETUP) & PSEL & PENABLE;
  assign in_acc    = acc_first | ((state == ACCESS) & PSEL & PENABLE);
  assign wcnt_eff  = acc_first ? 2'd0 : wcnt;
  assign PREADY    = in_acc & (wcnt_eff == WS);
  assign PSLVERR   = PREADY & dec.err;
  assign wr_commit = PREADY & PWRITE & ~dec.err;

  always_comb begin
    for (int c = 0; c < NCH; c++) ipr[c] = tsr[c][0] & ier[c];
  end

  always_comb begin
    rdata = '0;
    if (dec.ch_hit) begin
      case (dec.off)
        2'd0:    rdata = tcr[dec.ch];
        2'd1:    rdata = tdr[dec.ch];
        2'd2:    rdata = tsr[dec.ch];
        default: rdata = tcnt[dec.ch];
      endcase
    end else if (dec.ier) begin
      rdata = DW'(ier);
    end else if (dec.ipr) begin
      rdata = DW'(ipr);
    end
  end

  assign PRDATA = (PREADY & ~PWRITE & ~dec.err) ? rdata : '0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      wcnt  <= '0;
      ier   <= '0;
      irq_o <= 1'b0;
    end else begin
      if (wr_commit & dec.ier) ier <= NCH'(PWDATA);
      irq_o <= |ipr;
      if (PREADY) begin
        state <= IDLE;
        wcnt  <= '0;
      end else if (in_acc) begin
        state <= ACCESS;
        wcnt  <= wcnt_eff + 2'd1;
      end else if (PSEL & ~PENABLE) begin
        state <= SETUP;
        wcnt  <= '0;
      end else begin
        // covers idle bus, PSEL dropped mid-ACCESS, and PENABLE without SETUP
        state <= IDLE;
        wcnt  <= '0;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic hit;
    assign hit = wr_commit & dec.ch_hit & (dec.ch == CW'(c));
    apb_timer_regs_ch #(.DW(DW)) u_ch (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .wr_tcr  (hit & (dec.off == 2'd0)),
      .wr_tdr  (hit & (dec.off == 2'd1)),
      .wr_tsr  (hit & (dec.off == 2'd2)),
      .wdata   (PWDATA),
      .tsr_set (tset[c]),
      .tcr     (tcr[c]),
      .tdr     (tdr[c]),
      .tsr     (tsr[c]),
      .tdr_wr  (tdr_wr_o[c])
    );
  end
endmodule
